edge_detect: RTL and testbench

//  Streaming gradient edge detector; runs directly upstream of the line-drawing overlay stage.

---
 rtl/edge_detect_pkg.sv | 38 +++
 rtl/edge_detect_line_buffer.sv | 29 ++
 rtl/edge_detect.sv | 114 +++++++++++
 tb/tb_edge_detect.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/edge_detect_pkg.sv
// Shared pixel constants, cycle classification and stage-1 payload for the edge detector.
package edge_detect_pkg;

  localparam int unsigned PIX_W         = 8;
  localparam int unsigned GRAD_W        = PIX_W + 1;
  localparam int unsigned MAX_WIDTH_DEF = 256;
  localparam logic [PIX_W-1:0] PIX_EDGE = 8'hFF;
  localparam logic [PIX_W-1:0] PIX_BG   = 8'h00;

  typedef enum logic [1:0] {
    CYC_PIX   = 2'd0,
    CYC_LINE  = 2'd1,
    CYC_FRAME = 2'd2
  } cyc_e;

  typedef struct packed {
    logic             valid;
    logic             frame;
    logic             line;
    logic             up_self;
    logic [PIX_W-1:0] p;
    logic [PIX_W-1:0] l;
    logic [PIX_W-1:0] thr;
  } s1_t;

  // Frame marker wins over a simultaneous line marker.
  function automatic cyc_e classify(input logic frame, input logic line);
    if (frame)     return CYC_FRAME;
    else if (line) return CYC_LINE;
    else           return CYC_PIX;
  endfunction

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/edge_detect_line_buffer.sv
// One-row pixel store: synchronous registered read, read-before-write on the same address.
module edge_detect_line_buffer
  import edge_detect_pkg::*;
#(
  parameter int unsigned DEPTH  = MAX_WIDTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              i_re,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [PIX_W-1:0]  i_wdata,
  output logic [PIX_W-1:0]  o_rdata
);

  logic [PIX_W-1:0] r_mem [DEPTH];

  // Contents are left unreset; the first-row flag masks stale data.
  always_ff @(posedge Clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)   o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/edge_detect.sv
// Streaming gradient edge detector: |P-L| + |P-U| against a threshold, 2-cycle latency.
module edge_detect
  import edge_detect_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = MAX_WIDTH_DEF,
  parameter int unsigned ADDR_W    = $clog2(MAX_WIDTH)
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [PIX_W-1:0] PixelIn,
  input  logic             FrameIn,
  input  logic             LineIn,
  input  logic [PIX_W-1:0] Threshold,
  output logic [PIX_W-1:0] PixelOut,
  output logic             FrameOut,
  output logic             LineOut,
  output logic             LineTooLong
);

  localparam int unsigned XW = ADDR_W + 1;
  localparam logic [XW-1:0] X_MAX = XW'(MAX_WIDTH);

  cyc_e             w_cyc;
  logic             w_is_pix;
  logic             w_x_full;
  logic [PIX_W-1:0] w_left;
  logic [PIX_W-1:0] w_rd_data;
  logic [PIX_W-1:0] w_up;
  logic [GRAD_W-1:0] w_grad;
  s1_t              w_s1_next;

  logic [XW-1:0]    r_x;
  logic             r_first_row;
  logic [PIX_W-1:0] r_left;
  s1_t              r_s1;

  assign w_cyc    = classify(FrameIn, LineIn);
  assign w_is_pix = (w_cyc == CYC_PIX);
  assign w_x_full = (r_x == X_MAX);
  assign w_left   = (r_x == '0) ? PixelIn : r_left;

  edge_detect_line_buffer #(
    .DEPTH  (MAX_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_line_buffer (
    .Clk     (Clk),
    .nReset  (nReset),
    .i_re    (w_is_pix),
    .i_we    (w_is_pix && !w_x_full),
    .i_addr  (r_x[ADDR_W-1:0]),
    .i_wdata (PixelIn),
    .o_rdata (w_rd_data)
  );

  // Column counter, row flag, left-pixel register and overflow flag.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_x         <= '0;
      r_first_row <= 1'b1;
      r_left      <= '0;
      LineTooLong <= 1'b0;
    end else begin
      unique case (w_cyc)
        CYC_FRAME: begin
          r_x         <= '0;
          r_first_row <= 1'b1;
          LineTooLong <= 1'b0;
        end
        CYC_LINE: begin
          r_x         <= '0;
          r_first_row <= 1'b0;
        end
        default: begin
          r_left <= PixelIn;
          if (w_x_full) LineTooLong <= 1'b1;
          else          r_x         <= r_x + XW'(1);
        end
      endcase
    end
  end

  // Up neighbour is the pixel itself on the first row or past the buffered width.
  always_comb begin
    w_s1_next         = '0;
    w_s1_next.valid   = w_is_pix;
    w_s1_next.frame   = (w_cyc == CYC_FRAME);
    w_s1_next.line    = (w_cyc == CYC_LINE);
    w_s1_next.up_self = r_first_row || w_x_full;
    w_s1_next.p       = PixelIn;
    w_s1_next.l       = w_left;
    w_s1_next.thr     = Threshold;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) r_s1 <= '0;
    else         r_s1 <= w_s1_next;
  end

  assign w_up   = r_s1.up_self ? r_s1.p : w_rd_data;
  assign w_grad = GRAD_W'(abs_diff(r_s1.p, r_s1.l)) + GRAD_W'(abs_diff(r_s1.p, w_up));

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      PixelOut <= PIX_BG;
      FrameOut <= 1'b0;
      LineOut  <= 1'b0;
    end else begin
      PixelOut <= (r_s1.valid && (w_grad > GRAD_W'(r_s1.thr))) ? PIX_EDGE : PIX_BG;
      FrameOut <= r_s1.frame;
      LineOut  <= r_s1.line;
    end
  end

endmodule

// File: tb/tb_edge_detect.sv
// Scoreboard bench for edge_detect with a 4-pixel line buffer.
module tb_edge_detect;

  logic       Clk;
  logic       nReset;
  logic [7:0] PixelIn;
  logic       FrameIn;
  logic       LineIn;
  logic [7:0] Threshold;
  logic [7:0] PixelOut;
  logic       FrameOut;
  logic       LineOut;
  logic       LineTooLong;

  typedef struct {
    int         due;
    logic [9:0] exp;
  } exp_t;

  exp_t sb[$];
  int   mon_cyc  = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  edge_detect #(.MAX_WIDTH(4), .ADDR_W(2)) dut (
    .Clk         (Clk),
    .nReset      (nReset),
    .PixelIn     (PixelIn),
    .FrameIn     (FrameIn),
    .LineIn      (LineIn),
    .Threshold   (Threshold),
    .PixelOut    (PixelOut),
    .FrameOut    (FrameOut),
    .LineOut     (LineOut),
    .LineTooLong (LineTooLong)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, mon_cyc);
    end
  endtask

  // Output packed as {PixelOut, FrameOut, LineOut}.
  task automatic pix(input logic [7:0] p, input logic [7:0] thr, input logic [7:0] e);
    @(negedge Clk);
    PixelIn = p; FrameIn = 1'b0; LineIn = 1'b0; Threshold = thr;
    sb.push_back('{mon_cyc + 2, {e, 1'b0, 1'b0}});
  endtask

  task automatic frame(input logic with_line);
    @(negedge Clk);
    PixelIn = 8'hA5; FrameIn = 1'b1; LineIn = with_line;
    sb.push_back('{mon_cyc + 2, {8'h00, 1'b1, 1'b0}});
  endtask

  task automatic line();
    @(negedge Clk);
    PixelIn = 8'h5A; FrameIn = 1'b0; LineIn = 1'b1;
    sb.push_back('{mon_cyc + 2, {8'h00, 1'b0, 1'b1}});
  endtask

  task automatic pix_row(input logic [7:0] p [4], input logic [7:0] thr, input logic [7:0] e [4]);
    for (int i = 0; i < 4; i++) pix(p[i], thr, e[i]);
  endtask

  // Every cycle carries one item, so each due item is compared exactly on its cycle.
  initial begin
    exp_t item;
    forever begin
      @(posedge Clk);
      #1;
      mon_cyc++;
      while (sb.size() > 0 && sb[0].due <= mon_cyc) begin
        item = sb.pop_front();
        if (item.due < mon_cyc) check("late", 16'(mon_cyc), 16'(item.due));
        else                    check("out", {6'b0, PixelOut, FrameOut, LineOut}, {6'b0, item.exp});
      end
    end
  end

  initial begin
    logic [7:0] z4 [4];
    logic [7:0] f4 [4];
    z4 = '{8'h00, 8'h00, 8'h00, 8'h00};
    f4 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};

    nReset = 1'b0; PixelIn = 8'h00; FrameIn = 1'b0; LineIn = 1'b0; Threshold = 8'h00;
    repeat (3) @(negedge Clk);
    check("rst_pix",   16'(PixelOut),    16'h00);
    check("rst_frame", 16'(FrameOut),    16'h0);
    check("rst_line",  16'(LineOut),     16'h0);
    check("rst_ltl",   16'(LineTooLong), 16'h0);
    nReset = 1'b1;

    // Flat image: never an edge, markers delayed by two cycles.
    frame(1'b0);
    for (int r = 0; r < 3; r++) begin
      pix_row('{8'h40, 8'h40, 8'h40, 8'h40}, 8'h00, z4);
      line();
    end
    @(negedge Clk);
    check("flat_ltl", 16'(LineTooLong), 16'h0);

    // Vertical edge on the first row.
    frame(1'b0);
    pix_row('{8'd10, 8'd10, 8'd90, 8'd90}, 8'h20, '{8'h00, 8'h00, 8'hFF, 8'h00});
    line();

    // Horizontal edge; simultaneous Frame+Line counts as a frame marker.
    frame(1'b1);
    pix_row('{8'h10, 8'h10, 8'h10, 8'h10}, 8'h3F, z4);
    line();
    pix_row('{8'h50, 8'h50, 8'h50, 8'h50}, 8'h3F, f4);
    line();

    // Threshold boundary: G=0x20 against 0x20 then 0x1F.
    frame(1'b0);
    pix(8'h00, 8'h20, 8'h00);
    pix(8'h20, 8'h20, 8'h00);
    pix(8'h00, 8'h1F, 8'hFF);
    pix(8'h00, 8'h1F, 8'h00);
    line();

    // Threshold 0xFF: G=255 is not an edge, G=510 is.
    frame(1'b0);
    pix_row(z4, 8'hFF, z4);
    line();
    pix_row('{8'hFF, 8'h00, 8'hFF, 8'h00}, 8'hFF, '{8'h00, 8'h00, 8'hFF, 8'h00});
    line();

    // Overflow: 6-pixel lines into a 4-entry buffer.
    frame(1'b0);
    pix(8'h10, 8'h1F, 8'h00); pix(8'h20, 8'h1F, 8'h00); pix(8'h30, 8'h1F, 8'h00);
    pix(8'h40, 8'h1F, 8'h00); pix(8'h50, 8'h1F, 8'h00); pix(8'h60, 8'h1F, 8'h00);
    line();
    @(negedge Clk);
    check("ovf_set", 16'(LineTooLong), 16'h1);
    line();
    pix(8'h10, 8'h1F, 8'h00); pix(8'h20, 8'h1F, 8'h00); pix(8'h30, 8'h1F, 8'h00);
    pix(8'h40, 8'h1F, 8'h00); pix(8'h90, 8'h1F, 8'hFF); pix(8'h90, 8'h1F, 8'h00);
    line();
    @(negedge Clk);
    check("ovf_hold", 16'(LineTooLong), 16'h1);
    frame(1'b0);
    @(negedge Clk);
    check("ovf_clear", 16'(LineTooLong), 16'h0);

    // Mid-stream reset while an edge is on the output and the flag is set.
    pix(8'h00, 8'h00, 8'h00); pix(8'h40, 8'h00, 8'hFF); pix(8'h40, 8'h00, 8'h00);
    pix(8'h40, 8'h00, 8'h00); pix(8'h40, 8'h00, 8'h00);
    pix(8'h00, 8'h00, 8'hFF); pix(8'h00, 8'h00, 8'h00);
    @(negedge Clk);
    check("pre_rst_pix", 16'(PixelOut),    16'hFF);
    check("pre_rst_ltl", 16'(LineTooLong), 16'h1);
    nReset = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_pix",   16'(PixelOut),    16'h00);
    check("mid_rst_frame", 16'(FrameOut),    16'h0);
    check("mid_rst_line",  16'(LineOut),     16'h0);
    check("mid_rst_ltl",   16'(LineTooLong), 16'h0);
    repeat (2) @(negedge Clk);
    nReset = 1'b1;

    // Recovery from the next frame marker.
    frame(1'b0);
    pix_row('{8'd10, 8'd10, 8'd90, 8'd90}, 8'h20, '{8'h00, 8'h00, 8'hFF, 8'h00});
    line();

    repeat (4) @(negedge Clk);
    check("sb_drained", 16'(sb.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
